// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// The optional return stack is selected by PC_SEQ_CALL_STACK_EN.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_REL,
        SEL_ABS,
        SEL_CALL,
        SEL_RET
    } pc_sel_t;

    // Sign-extends the low 'width' bits of val to 32 bits (width in 1..32).
    function automatic logic [31:0] sign_ext(input logic [31:0] val, input int unsigned width);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << width;
        if (val[width-1])
            return val | mask;
        else
            return val & ~mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO of return addresses for the sequencer's call/return feature.
// Pushes when full and pops when empty are ignored; the caller flags them.
module ret_stack #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign full  = (ptr == PTR_W'(DEPTH));
    assign empty = (ptr == '0);
    assign dout  = empty ? '0 : mem[IDX_W'(ptr - PTR_W'(1))];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (pop && !empty)
            ptr <= ptr - PTR_W'(1);
        else if (push && !full)
            ptr <= ptr + PTR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!clr && !pop && push && !full)
            mem[IDX_W'(ptr)] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer with start/done run handshake.
// Define PC_SEQ_CALL_STACK_EN to enable call/return via a return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned TGT_W     = 8,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned STK_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt,
    input  logic             jmp_en,
    input  logic             jmp_abs,
    input  logic [TGT_W-1:0] target,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             running,
    output logic             done,
    output logic             stack_err
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);

    state_t          state, state_nxt;
    pc_sel_t         pc_sel;
    logic            restart;
    logic [PC_W-1:0] pc_nxt, pc_inc, pc_rel, pc_abs;

    assign pc_inc = prog_ctr + PC_W'(1);
    assign pc_rel = prog_ctr + PC_W'(sign_ext(32'(target), TGT_W));
    assign pc_abs = PC_W'(target);

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

`ifdef PC_SEQ_CALL_STACK_EN
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_dout;

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (restart),
        .push    (stk_push),
        .pop     (stk_pop),
        .din     (pc_inc),
        .dout    (stk_dout),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    assign stk_push = (pc_sel == SEL_CALL);
    assign stk_pop  = (pc_sel == SEL_RET);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stack_err <= 1'b0;
        else if (restart)
            stack_err <= 1'b0;
        else if ((stk_push && stk_full) || (stk_pop && stk_empty))
            stack_err <= 1'b1;
    end
`else
    logic unused_strobes;
    assign unused_strobes = call_en | ret_en;
    assign stack_err      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_sel    = SEL_HOLD;
        restart   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    restart   = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt)
                    state_nxt = ST_DONE;
`ifdef PC_SEQ_CALL_STACK_EN
                else if (ret_en)
                    pc_sel = SEL_RET;
                else if (call_en)
                    pc_sel = SEL_CALL;
`endif
                else if (jmp_en)
                    pc_sel = jmp_abs ? SEL_ABS : SEL_REL;
                else
                    pc_sel = SEL_INC;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = prog_ctr;
        if (restart)
            pc_nxt = RST_PC;
        else begin
            case (pc_sel)
                SEL_INC:           pc_nxt = pc_inc;
                SEL_REL:           pc_nxt = pc_rel;
                SEL_ABS, SEL_CALL: pc_nxt = pc_abs;
`ifdef PC_SEQ_CALL_STACK_EN
                // An underflowing return falls through to the next instruction.
                SEL_RET:           pc_nxt = stk_empty ? pc_inc : stk_dout;
`endif
                default:           pc_nxt = prog_ctr;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            prog_ctr <= RST_PC;
        end else begin
            state    <= state_nxt;
            prog_ctr <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed checks of pc_sequencer against a behavioural model.
// Exercises the return stack too when PC_SEQ_CALL_STACK_EN is defined.
module tb_pc_sequencer;

    localparam int PC_W   = 10;
    localparam int TGT_W  = 8;
    localparam int DEPTH  = 2;
    localparam int PC_MOD = 1 << PC_W;
`ifdef PC_SEQ_CALL_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0, halt = 1'b0, jmp_en = 1'b0, jmp_abs = 1'b0;
    logic             call_en = 1'b0, ret_en = 1'b0;
    logic [TGT_W-1:0] target = '0;
    logic [PC_W-1:0]  prog_ctr;
    logic             running, done, stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = idle, 1 = run, 2 = done
    int m_state;
    int m_pc;
    bit m_err;
    int m_stk[$];

    pc_sequencer #(
        .PC_W      (PC_W),
        .TGT_W     (TGT_W),
        .RESET_VEC (0),
        .STK_DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .halt      (halt),
        .jmp_en    (jmp_en),
        .jmp_abs   (jmp_abs),
        .target    (target),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .prog_ctr  (prog_ctr),
        .running   (running),
        .done      (done),
        .stack_err (stack_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_edge();
        int off;
        if (m_state == 1) begin
            if (halt)
                m_state = 2;
            else if (STK_EN && ret_en) begin
                if (m_stk.size() == 0) begin
                    m_pc  = (m_pc + 1) % PC_MOD;
                    m_err = 1'b1;
                end else
                    m_pc = m_stk.pop_back();
            end else if (STK_EN && call_en) begin
                if (m_stk.size() == DEPTH)
                    m_err = 1'b1;
                else
                    m_stk.push_back((m_pc + 1) % PC_MOD);
                m_pc = int'(target) % PC_MOD;
            end else if (jmp_en) begin
                if (jmp_abs)
                    m_pc = int'(target) % PC_MOD;
                else begin
                    off  = (int'(target) >= 128) ? int'(target) - 256 : int'(target);
                    m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
                end
            end else
                m_pc = (m_pc + 1) % PC_MOD;
        end else if (start) begin
            m_state = 1;
            m_pc    = 0;
            m_err   = 1'b0;
            m_stk.delete();
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"}, prog_ctr, m_pc);
        check({tag, ".running"}, running, (m_state == 1) ? 1 : 0);
        check({tag, ".done"}, done, (m_state == 2) ? 1 : 0);
        check({tag, ".stack_err"}, stack_err, m_err);
    endtask

    task automatic step(input string tag, input bit st, input bit h, input bit je, input bit ja,
                        input bit ce, input bit re, input logic [TGT_W-1:0] tg);
        start   = st;
        halt    = h;
        jmp_en  = je;
        jmp_abs = ja;
        call_en = ce;
        ret_en  = re;
        target  = tg;
        @(posedge clock);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    initial begin
        model_reset();
        #2;
        compare_model("reset");
        check("reset.pc_const", prog_ctr, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // start pulse then free-running increments
        step("t2", 1, 0, 0, 0, 0, 0, 8'h00);
        check("t2.pc0", prog_ctr, 0);
        for (int i = 1; i < 5; i++) begin
            step("t2", 0, 0, 0, 0, 0, 0, 8'h00);
            check("t2.pc_inc", prog_ctr, i);
        end
        check("t2.running", running, 1);

        // relative wrap backwards, then absolute
        step("t3", 0, 0, 0, 0, 0, 0, 8'h00);
        check("t3.pc5", prog_ctr, 5);
        step("t3", 0, 0, 1, 0, 0, 0, 8'hF8);
        check("t3.rel", prog_ctr, 10'h3FD);
        step("t3", 0, 0, 1, 1, 0, 0, 8'h20);
        check("t3.abs", prog_ctr, 10'h020);

        // halt beats jump, then restart
        step("t4", 0, 0, 1, 1, 0, 0, 8'h30);
        step("t4", 0, 1, 1, 1, 0, 0, 8'h77);
        check("t4.hold", prog_ctr, 10'h030);
        check("t4.done", done, 1);
        step("t4", 0, 0, 1, 1, 0, 0, 8'h55);
        check("t4.ignored", prog_ctr, 10'h030);
        step("t4", 1, 0, 0, 0, 0, 0, 8'h00);
        check("t4.restart", prog_ctr, 0);
        check("t4.done_clr", done, 0);

        // nested call/return (stack feature only)
        step("t5", 0, 0, 1, 1, 0, 0, 8'h10);
        step("t5", 0, 0, 0, 0, 1, 0, 8'h40);
        step("t5", 0, 0, 0, 0, 0, 0, 8'h00);
        step("t5", 0, 0, 0, 0, 1, 0, 8'h50);
        step("t5", 0, 0, 0, 0, 0, 1, 8'h00);
        if (STK_EN) check("t5.ret1", prog_ctr, 10'h042);
        step("t5", 0, 0, 0, 0, 0, 1, 8'h00);
        if (STK_EN) check("t5.ret2", prog_ctr, 10'h011);

        // return with an empty stack after a fresh start
        step("t6", 0, 1, 0, 0, 0, 0, 8'h00);
        step("t6", 1, 0, 0, 0, 0, 0, 8'h00);
        step("t6", 0, 0, 1, 1, 0, 0, 8'h07);
        step("t6", 0, 0, 0, 0, 0, 1, 8'h00);
        check("t6.pc", prog_ctr, 10'h008);
        if (STK_EN) check("t6.err", stack_err, 1);
        step("t6", 0, 0, 0, 0, 0, 0, 8'h00);
        step("t6", 0, 1, 0, 0, 0, 0, 8'h00);
        step("t6", 1, 0, 0, 0, 0, 0, 8'h00);
        check("t6.err_clr", stack_err, 0);

        // overflow: third call with DEPTH=2 still jumps
        step("ovf", 0, 0, 0, 0, 1, 0, 8'h21);
        step("ovf", 0, 0, 0, 0, 1, 0, 8'h31);
        step("ovf", 0, 0, 0, 0, 1, 0, 8'h41);
        if (STK_EN) check("ovf.err", stack_err, 1);

        // asynchronous reset mid-run
        step("t1", 0, 0, 1, 1, 0, 0, 8'h12);
        check("t1.pc12", prog_ctr, 10'h012);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_model("t1");
        check("t1.pc0", prog_ctr, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            step("rnd",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0,
                 1'($urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 TGT_W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
